// File: rtl/zstd_block_parser.sv
// Zstandard block-sequence parser: decodes 3-byte block headers and streams Raw/RLE/Compressed payload at 2 bytes/cycle.
// Define ZSTD_CHECKSUM_EN to capture the 4-byte trailing content checksum before done.
module zstd_block_parser #(
    parameter int MAX_BLOCK_SIZE = 131072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        carry_valid,
    input  logic [7:0]  carry_byte,
`ifdef ZSTD_CHECKSUM_EN
    input  logic        checksum_flag,
    output logic [31:0] content_checksum,
`endif
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [1:0]  out_count,
    output logic [1:0]  out_type,
    output logic        out_last,
    input  logic        out_ready,
    output logic        hdr_valid,
    output logic        last_block,
    output logic [1:0]  block_type,
    output logic [20:0] block_size,
    output logic        error,
    output logic        done
);

`ifdef ZSTD_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, RLE_BYTE, RLE_EMIT, CHECKSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, RLE_BYTE, RLE_EMIT, DONE} state_t;
`endif

    localparam logic [20:0] MAX_SIZE = 21'(MAX_BLOCK_SIZE);

    state_t      state, state_n, blk_next, hdr_blk_next;
    logic        sp_v;
    logic [7:0]  sp_b;
    logic [1:0]  hcnt;
    logic [23:0] hbuf, h_new;
    logic [20:0] remaining;
    logic [7:0]  rle_byte;

    logic        can_load, acc;
    logic [1:0]  need, avail, take, rle_n;
    logic [7:0]  w0, w1, w2;
    logic        hdr_done, h_bad;
    logic        pay_beat, pay_end, rle_got, rle_beat, rle_end;

`ifdef ZSTD_CHECKSUM_EN
    logic        cs_en;
    logic [1:0]  ccnt;
    logic [31:0] cbuf, c_new;
    logic        cs_done;
`endif

    function automatic logic [1:0] min2(input logic [20:0] v);
        return (v >= 21'd2) ? 2'd2 : v[1:0];
    endfunction

    assign can_load = !out_valid || out_ready;
    assign done     = (state == DONE);

    // Bytes wanted from the stream this cycle by the current state
    always_comb begin
        need = 2'd0;
        case (state)
            HDR:      need = 2'd3 - hcnt;
            PAYLOAD:  need = can_load ? min2(remaining) : 2'd0;
            RLE_BYTE: need = 2'd1;
`ifdef ZSTD_CHECKSUM_EN
            CHECKSUM: need = (ccnt == 2'd0) ? 2'd3 : 2'd0 - ccnt;
`endif
            default:  need = 2'd0;
        endcase
    end

    // A word is taken only if at most one of its bytes is left over for the spare register
    assign in_ready = need > {1'b0, sp_v};
    assign acc      = in_valid && in_ready;
    assign avail    = {1'b0, sp_v} + (acc ? 2'd2 : 2'd0);
    assign take     = (need < avail) ? need : avail;

    always_comb begin
        if (sp_v) begin
            w0 = sp_b;
            w1 = in_data[7:0];
            w2 = in_data[15:8];
        end else begin
            w0 = in_data[7:0];
            w1 = in_data[15:8];
            w2 = 8'h00;
        end
    end

    always_comb begin
        case (take)
            2'd1:    h_new = {w0, hbuf[23:8]};
            2'd2:    h_new = {w1, w0, hbuf[23:16]};
            2'd3:    h_new = {w2, w1, w0};
            default: h_new = hbuf;
        endcase
    end

    assign hdr_done = (state == HDR) && (({1'b0, hcnt} + {1'b0, take}) == 3'd3);
    assign h_bad    = (h_new[2:1] == 2'b11) || (h_new[23:3] > MAX_SIZE);
    assign pay_beat = (state == PAYLOAD) && (take != 2'd0);
    assign pay_end  = pay_beat && (remaining == {19'd0, take});
    assign rle_got  = (state == RLE_BYTE) && (take != 2'd0);
    assign rle_n    = min2(remaining);
    assign rle_beat = (state == RLE_EMIT) && can_load;
    assign rle_end  = rle_beat && (remaining == {19'd0, rle_n});

`ifdef ZSTD_CHECKSUM_EN
    always_comb begin
        case (take)
            2'd1:    c_new = {w0, cbuf[31:8]};
            2'd2:    c_new = {w1, w0, cbuf[31:16]};
            2'd3:    c_new = {w2, w1, w0, cbuf[31:24]};
            default: c_new = cbuf;
        endcase
    end
    assign cs_done = (state == CHECKSUM) && (({1'b0, ccnt} + {1'b0, take}) == 3'd4);
`endif

    // Where a block ends up once its payload is exhausted
    always_comb begin
        blk_next     = last_block ? DONE : HDR;
        hdr_blk_next = h_new[0] ? DONE : HDR;
`ifdef ZSTD_CHECKSUM_EN
        if (last_block && cs_en) blk_next = CHECKSUM;
        if (h_new[0] && cs_en)   hdr_blk_next = CHECKSUM;
`endif
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start) state_n = HDR;
            HDR: begin
                if (hdr_done) begin
                    if (h_bad)                     state_n = IDLE;
                    else if (h_new[2:1] == 2'd1)   state_n = RLE_BYTE;
                    else if (h_new[23:3] == 21'd0) state_n = hdr_blk_next;
                    else                           state_n = PAYLOAD;
                end
            end
            PAYLOAD:  if (pay_end) state_n = blk_next;
            RLE_BYTE: if (rle_got) state_n = (remaining == 21'd0) ? blk_next : RLE_EMIT;
            RLE_EMIT: if (rle_end) state_n = blk_next;
`ifdef ZSTD_CHECKSUM_EN
            CHECKSUM: if (cs_done) state_n = DONE;
`endif
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_v       <= 1'b0;
            hcnt       <= 2'd0;
            remaining  <= 21'd0;
            hdr_valid  <= 1'b0;
            last_block <= 1'b0;
            block_type <= 2'd0;
            block_size <= 21'd0;
            error      <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 16'h0000;
            out_count  <= 2'd0;
            out_type   <= 2'd0;
            out_last   <= 1'b0;
        end else begin
            hdr_valid <= hdr_done;
            if (state == IDLE && start) begin
                sp_v  <= carry_valid;
                error <= 1'b0;
                hcnt  <= 2'd0;
            end else if (acc) begin
                sp_v <= (avail != take);
            end else if (take != 2'd0) begin
                sp_v <= 1'b0;
            end
            if (state == HDR) hcnt <= hdr_done ? 2'd0 : hcnt + take;
            if (hdr_done) begin
                last_block <= h_new[0];
                block_type <= h_new[2:1];
                block_size <= h_new[23:3];
                remaining  <= h_new[23:3];
                if (h_bad) error <= 1'b1;
            end else if (pay_beat) begin
                remaining <= remaining - {19'd0, take};
            end else if (rle_beat) begin
                remaining <= remaining - {19'd0, rle_n};
            end
            // Output stage: one-deep register, held while out_ready is low
            if (pay_beat) begin
                out_valid <= 1'b1;
                out_data  <= (take == 2'd2) ? {w1, w0} : {8'h00, w0};
                out_count <= take;
                out_type  <= block_type;
                out_last  <= last_block && pay_end;
            end else if (rle_beat) begin
                out_valid <= 1'b1;
                out_data  <= (rle_n == 2'd2) ? {rle_byte, rle_byte} : {8'h00, rle_byte};
                out_count <= rle_n;
                out_type  <= 2'd1;
                out_last  <= last_block && rle_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // The only byte that can ever be left over is the high byte of the accepted word
    always_ff @(posedge clk) begin
        if (state == IDLE && start) sp_b <= carry_byte;
        else if (acc)               sp_b <= in_data[15:8];
        if (state == HDR) hbuf <= h_new;
        if (rle_got)      rle_byte <= w0;
    end

`ifdef ZSTD_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_en            <= 1'b0;
            ccnt             <= 2'd0;
            content_checksum <= 32'h0;
        end else begin
            if (state == IDLE && start) begin
                cs_en <= checksum_flag;
                ccnt  <= 2'd0;
            end
            if (state == CHECKSUM) ccnt <= cs_done ? 2'd0 : ccnt + take;
            if (cs_done) content_checksum <= c_new;
        end
    end

    always_ff @(posedge clk) begin
        if (state == CHECKSUM) cbuf <= c_new;
    end
`endif

endmodule

// File: tb/tb_zstd_block_parser.sv
// Scoreboard bench for zstd_block_parser: frames built from block descriptions, expected bytes/headers queued, monitor compares.
module tb_zstd_block_parser;
    logic        clk, reset, start, carry_valid;
    logic [7:0]  carry_byte;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        out_valid, out_last, out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_count, out_type;
    logic        hdr_valid, last_block, error, done;
    logic [1:0]  block_type;
    logic [20:0] block_size;
`ifdef ZSTD_CHECKSUM_EN
    logic [31:0] content_checksum;
`endif

    zstd_block_parser dut (
        .clk(clk), .reset(reset), .start(start),
        .carry_valid(carry_valid), .carry_byte(carry_byte),
`ifdef ZSTD_CHECKSUM_EN
        .checksum_flag(1'b0), .content_checksum(content_checksum),
`endif
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
        .out_type(out_type), .out_last(out_last), .out_ready(out_ready),
        .hdr_valid(hdr_valid), .last_block(last_block), .block_type(block_type),
        .block_size(block_size), .error(error), .done(done)
    );

    typedef struct {
        logic [7:0] b;
        logic [1:0] t;
        logic       last;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] hdr_q[$];
    logic [7:0]  stream[$];
    int          checks = 0, failures = 0;
    int          done_cnt = 0;
    int          hold_req = 0;
    int          out_gap = 0;
    bit          stall_prev = 0;
    logic [21:0] held;
    logic [63:0] outs_all;

    assign outs_all = {14'd0, out_valid, out_data, out_count, out_type, out_last, hdr_valid,
                       last_block, block_type, block_size, error, done, in_ready};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: serialise a block per the format and record what must come out
    task automatic add_hdr(input bit last, input logic [1:0] t, input int size);
        logic [23:0] h;
        h = {size[20:0], t, last};
        stream.push_back(h[7:0]);
        stream.push_back(h[15:8]);
        stream.push_back(h[23:16]);
        hdr_q.push_back({last, t, size[20:0]});
    endtask

    task automatic add_block(input bit last, input logic [1:0] t, input int size, input int base);
        logic [7:0] b;
        exp_t       e;
        add_hdr(last, t, size);
        if (t == 2'd1) begin
            b = (base < 0) ? 8'($urandom) : 8'(base);
            stream.push_back(b);
            for (int i = 0; i < size; i++) begin
                e.b = b; e.t = 2'd1; e.last = 1'b0;
                exp_q.push_back(e);
            end
        end else begin
            for (int i = 0; i < size; i++) begin
                b = (base < 0) ? 8'($urandom) : 8'(base + i * 17);
                stream.push_back(b);
                e.b = b; e.t = t; e.last = 1'b0;
                exp_q.push_back(e);
            end
        end
        if (last && size > 0) begin
            e = exp_q.pop_back();
            e.last = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_req > 0) begin
                out_ready = 1'b0;
                hold_req--;
            end else begin
                out_ready = ($urandom_range(99) >= out_gap);
            end
        end
    end

    // Monitor: compares every header pulse and every consumed beat against the queues
    initial begin
        exp_t        e;
        logic [23:0] h;
        logic        lastexp;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    chk("stall_hold", {42'd0, out_valid, out_data, out_count, out_type, out_last}, {42'd0, held});
                stall_prev = out_valid && !out_ready;
                held = {out_valid, out_data, out_count, out_type, out_last};
                if (hdr_valid) begin
                    if (hdr_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL hdr_unexpected: got last=%0d type=%0d size=%0d expected none",
                                 last_block, block_type, block_size);
                    end else begin
                        h = hdr_q.pop_front();
                        chk("hdr_fields", {40'd0, last_block, block_type, block_size}, {40'd0, h});
                    end
                end
                if (done) done_cnt++;
                if (out_valid && out_ready) begin
                    chk("out_count_range", {63'd0, (out_count == 2'd1 || out_count == 2'd2)}, 64'd1);
                    lastexp = 1'b0;
                    for (int k = 0; k < int'(out_count); k++) begin
                        if (exp_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL beat_unexpected: got byte 0x%0h expected none",
                                     (k == 0) ? out_data[7:0] : out_data[15:8]);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_byte", {54'd0, out_type, (k == 0) ? out_data[7:0] : out_data[15:8]},
                                {54'd0, e.t, e.b});
                            lastexp = e.last;
                        end
                    end
                    chk("out_last", {63'd0, out_last}, {63'd0, lastexp});
                    if (out_count == 2'd1) chk("pad_zero", {56'd0, out_data[15:8]}, 64'd0);
                end
            end
        end
    end

    // Drives one frame from `stream`; optional reset abort at cycle abort_at
    task automatic run_frame(input bit cv, input bit exp_err, input int in_gap,
                             input int abort_at, input int hold_at);
        logic [15:0] words[$];
        logic [7:0]  cb, lo, hi;
        int          wi, done0;
        bit          finished, aborted;
        cb = cv ? stream.pop_front() : 8'($urandom);
        for (int i = 0; i < stream.size(); i += 2) begin
            lo = stream[i];
            hi = (i + 1 < stream.size()) ? stream[i + 1] : 8'($urandom);
            words.push_back({hi, lo});
        end
        stream.delete();
        @(posedge clk); #1;
        start = 1'b1; carry_valid = cv; carry_byte = cb;
        @(posedge clk); #1;
        start = 1'b0; carry_valid = 1'b0;
        chk("error_cleared_by_start", {63'd0, error}, 64'd0);
        done0 = done_cnt; wi = 0; finished = 0; aborted = 0;
        for (int cyc = 0; cyc < 4000 && !finished && !aborted; cyc++) begin
            if (cyc == hold_at) hold_req = 3;
            if (cyc == abort_at) begin
                in_valid = 1'b0;
                reset = 1'b1;
                #2;
                chk("reset_async_zero", outs_all, 64'd0);
                @(posedge clk); #1;
                chk("reset_edge_zero", outs_all, 64'd0);
                exp_q.delete();
                hdr_q.delete();
                reset = 1'b0;
                aborted = 1;
            end else begin
                in_valid = (wi < words.size()) && ($urandom_range(99) >= in_gap);
                in_data  = in_valid ? words[wi] : 16'($urandom);
                @(negedge clk);
                if (in_valid && in_ready) wi++;
                @(posedge clk); #1;
                if (done_cnt != done0 || (exp_err && error)) finished = 1;
            end
        end
        in_valid = 1'b0;
        if (!aborted) begin
            chk("frame_completed", {63'd0, finished}, 64'd1);
            for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(posedge clk);
            repeat (8) @(posedge clk);
            #1;
            chk("exp_drained", 64'(exp_q.size()), 64'd0);
            chk("hdr_drained", 64'(hdr_q.size()), 64'd0);
            chk("words_accepted", 64'(wi), 64'(words.size()));
            chk("done_pulses", 64'(done_cnt - done0), exp_err ? 64'd0 : 64'd1);
            chk("error_final", {63'd0, error}, {63'd0, exp_err});
            chk("idle_in_ready", {63'd0, in_ready}, 64'd0);
        end
    endtask

    initial begin
        int nb, sz;
        reset = 1'b1; start = 1'b0; carry_valid = 1'b0; carry_byte = 8'h00;
        in_valid = 1'b0; in_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", outs_all, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", outs_all, 64'd0);

        out_gap = 0;
        add_block(1'b1, 2'd0, 5, 8'hAA);
        run_frame(1'b0, 1'b0, 0, -1, -1);

        add_block(1'b1, 2'd1, 7, 8'h5A);
        run_frame(1'b0, 1'b0, 0, -1, -1);

        add_hdr(1'b1, 2'd3, 0);
        run_frame(1'b0, 1'b1, 0, -1, -1);

        add_block(1'b0, 2'd0, 2, 8'h11);
        add_block(1'b1, 2'd0, 4, 8'h33);
        run_frame(1'b1, 1'b0, 0, -1, 4);

        add_hdr(1'b0, 2'd2, 21'h1FFFFF);
        run_frame(1'b0, 1'b1, 0, -1, -1);

        add_hdr(1'b1, 2'd1, 131073);
        run_frame(1'b0, 1'b1, 20, -1, -1);

        add_block(1'b1, 2'd0, 100, -1);
        run_frame(1'b0, 1'b0, 0, 20, -1);
        add_block(1'b1, 2'd0, 9, -1);
        run_frame(1'b0, 1'b0, 0, -1, -1);

        for (int f = 0; f < 12; f++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                sz = ($urandom_range(3) == 0) ? 0 : $urandom_range(1, 20);
                add_block(b == nb - 1, 2'($urandom_range(2)), sz, -1);
            end
            out_gap = $urandom_range(0, 40);
            run_frame(1'($urandom_range(1)), 1'b0, $urandom_range(0, 40), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
